// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with parity/stop checking and a
// one-entry valid/ready holding register.
// Optional build macro UART_RX_MAJORITY_EN: when defined, every bit value is
// a 2-of-3 vote over the ticks around the bit centre; otherwise a single
// centre-tick sample is used.

package uart_pkg;
    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_e;
endpackage

module uart_rx #(
    parameter int                DATA_BITS   = 8,
    parameter int                STOP_BITS   = 1,
    parameter uart_pkg::parity_e PARITY_MODE = uart_pkg::PARITY_NONE,
    parameter int                OVERSAMPLE  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rxd,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);
    import uart_pkg::*;

    localparam int CW = $clog2(OVERSAMPLE + 1);
    localparam int BW = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
    // The vote needs the centre+1 sample, so every decision lands one tick late.
    localparam int VOTE_LAG = 1;
`else
    localparam int VOTE_LAG = 0;
`endif
    localparam logic [CW-1:0] START_DEC  = CW'(OVERSAMPLE / 2 - 1 + VOTE_LAG);
    localparam logic [CW-1:0] BIT_DEC    = CW'(OVERSAMPLE);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP  = (STOP_BITS == 2);
    localparam bit            HAS_PARITY = (PARITY_MODE != PARITY_NONE);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_e;

    state_e               r_state;
    logic                 r_sync1, r_sync2;
    logic [CW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_acc;
    logic                 r_perr;
    logic                 r_ferr;

    logic                 w_rxs;
    logic                 w_prev;
    logic                 w_bit;
    logic [CW-1:0]        w_cnt_nxt;
    logic                 w_bit_dec;
    logic                 w_done;
    logic                 w_done_ferr;

    assign w_rxs = r_sync2;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;   // [0] = rxs on previous tick, [1] = two ticks ago

    // Keep the last two tick samples for edge detection and the vote
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_hist <= 2'b11;
        else if (sample_tick) r_hist <= {r_hist[0], w_rxs};
    end

    assign w_prev = r_hist[0];
    assign w_bit  = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxs) | (r_hist[0] & w_rxs);
`else
    logic r_hist;         // rxs on previous tick

    // Remember the previous tick sample for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_hist <= 1'b1;
        else if (sample_tick) r_hist <= w_rxs;
    end

    assign w_prev = r_hist;
    assign w_bit  = w_rxs;
`endif

    assign w_cnt_nxt   = r_tick_cnt + 1'b1;
    assign w_bit_dec   = (w_cnt_nxt == BIT_DEC);
    assign w_done      = sample_tick && (r_state == S_STOP) && w_bit_dec &&
                         (r_stop_cnt == LAST_STOP);
    assign w_done_ferr = r_ferr | ~w_bit;

    // Two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Frame FSM: start detect, centre sampling, deserialize, parity and stop checks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par_acc  <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else if (sample_tick) begin
            case (r_state)
                S_IDLE: begin
                    // Edge, not level: a line stuck low never re-triggers
                    if (!w_rxs && w_prev) begin
                        r_tick_cnt <= '0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_cnt_nxt == START_DEC) begin
                        r_tick_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_par_acc  <= 1'b0;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                        r_state    <= w_bit ? S_IDLE : S_DATA;
                    end else begin
                        r_tick_cnt <= w_cnt_nxt;
                    end
                end
                S_DATA: begin
                    if (w_bit_dec) begin
                        r_tick_cnt <= '0;
                        r_shift    <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_par_acc  <= r_par_acc ^ w_bit;
                        r_bit_idx  <= r_bit_idx + 1'b1;
                        if (r_bit_idx == LAST_BIT)
                            r_state <= HAS_PARITY ? S_PARITY : S_STOP;
                    end else begin
                        r_tick_cnt <= w_cnt_nxt;
                    end
                end
                S_PARITY: begin
                    if (w_bit_dec) begin
                        r_tick_cnt <= '0;
                        r_perr     <= (PARITY_MODE == PARITY_ODD) ? ~(r_par_acc ^ w_bit)
                                                                  :  (r_par_acc ^ w_bit);
                        r_state    <= S_STOP;
                    end else begin
                        r_tick_cnt <= w_cnt_nxt;
                    end
                end
                S_STOP: begin
                    if (w_bit_dec) begin
                        r_tick_cnt <= '0;
                        r_ferr     <= w_done_ferr;
                        if (r_stop_cnt == LAST_STOP) begin
                            // Leave at the stop centre so a back-to-back start edge is seen
                            r_stop_cnt <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end else begin
                        r_tick_cnt <= w_cnt_nxt;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // One-entry holding register with valid/ready handshake and overrun pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (w_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_valid   <= 1'b1;
                    rx_data    <= r_shift;
                    parity_err <= r_perr;
                    frame_err  <= w_done_ferr;
                end else begin
                    // Held word wins; the new one is dropped
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
